sparc_exu_rml_wincnt: RTL and testbench
=======================================

Name: sparc_exu_rml_wincnt

Overview:
Per-thread register-window bookkeeping for the EXU register management logic: holds CWP, CANSAVE, CANRESTORE and CLEANWIN for 4 threads.
It evaluates SAVE/RESTORE in M stage, flags spill/fill/clean-window traps, and commits new counter values.
On commit it drives a one-outstanding swap handshake to the IRF so the IRF can exchange window contents.
It sits between the ECL (decode/kill) and the IRF window-swap port, and its CWP ±1 arithmetic uses sparc_exu_rml_inc3.

Parameters:
NWIN, 8, number of register windows; fixed by 3-bit CWP width.
NTHR, 4, number of hardware threads; fixed by 2-bit tid.

Ports:
rclk  in  1  core clock
reset  in  1  synchronous, active-high reset
ecl_rml_save_e  in  1  SAVE valid in E stage
ecl_rml_restore_e  in  1  RESTORE valid in E stage; never asserted together with save_e
ecl_rml_tid_e  in  2  thread of E-stage op
ecl_rml_kill_m  in  1  kills the M-stage op
tlu_rml_wr_en  in  1  WRPR write strobe
tlu_rml_wr_sel  in  2  write target: 00 CWP, 01 CANSAVE, 10 CANRESTORE, 11 CLEANWIN
tlu_rml_wr_tid  in  2  thread of WRPR write
tlu_rml_wr_data  in  3  WRPR write value
irf_rml_swap_ack  in  1  IRF swap done, one-cycle pulse
rml_ecl_busy  out  1  window op in M or swap outstanding; ECL holds save/restore and TLU holds CWP writes while high
rml_ecl_spill_m  out  1  spill trap, M stage
rml_ecl_fill_m  out  1  fill trap, M stage
rml_ecl_clean_m  out  1  clean_window trap, M stage
rml_cwp_all  out  12  CWP of thr3..thr0, 3 bits each
rml_irf_swap_req  out  1  swap request
rml_irf_swap_tid  out  2  swap thread
rml_irf_old_cwp  out  3  window being left
rml_irf_new_cwp  out  3  window being entered

Behaviour:
- Reset values (per thread): CWP=0, CANSAVE=6, CANRESTORE=0, CLEANWIN=7.
- Reset values (outputs and internal state): all trap outputs 0, swap_req 0, M-valid 0, FSM IDLE.
- Reset asserted mid-swap: swap_req drops the next cycle, and an ack arriving during or after reset is ignored.
- E->M: save_e/restore_e/tid_e are flopped when busy=0; any request presented while busy=1 is dropped (bench asserts this never happens).
- M-stage evaluation reads the registered counters of tid_m.
- SAVE evaluation, in priority order:
  - CANSAVE==0 -> spill_m=1.
  - else CLEANWIN==CANRESTORE -> clean_m=1.
  - else commit: CWP+1 mod 8, CANSAVE-1, CANRESTORE+1.
- RESTORE evaluation:
  - CANRESTORE==0 -> fill_m=1.
  - else commit: CWP-1 mod 8, CANSAVE+1, CANRESTORE-1.
- Trap outputs are gated by ~kill_m and are asserted only in the single M cycle. Killed or trapped ops change no state.
- Commit timing: counters update at the end of the M cycle, so new CWP is visible on rml_cwp_all one cycle after M.
- Swap FSM, IDLE->SWAP on commit:
  - swap_req=1 from the cycle after M, with tid/old/new held stable until ack.
  - In SWAP: ack -> IDLE; swap_req deasserts the cycle after ack.
  - Ack in IDLE is ignored.
- busy = M-valid | (state==SWAP).
- WRPR CWP write (sel 00): accepted only when busy=0. It sets CWP and launches a swap through the same FSM (old=previous CWP, new=data). Writing the current value still swaps. Ignored when busy=1.
- WRPR counter writes (sel 01/10/11): always accepted; effective next cycle.
  - Same thread and same cycle as an M commit: the TLU value wins for the written field; the commit still updates the other fields.
- CWP arithmetic wraps 7->0 on save and 0->7 on restore. Counter arithmetic stays in 0..6 by construction, and WRPR values are written unchecked.

Decomposition:
- Shared package: NWIN, NTHR, reset constants (CANSAVE_RST=6, CLEANWIN_RST=7), wr_sel encodings, FSM state encoding (IDLE=0, SWAP=1).
- Sub-module: sparc_exu_rml_inc3, instantiated once on the M-stage CWP (inc=save).
- Counter ±1 is done inline.

Test Plan:
- Reset, then thr0 SAVE x6 spaced past each ack -> CWP 1..6, CANSAVE 6->0, CANRESTORE 0->6, six swaps with old/new = (0,1)...(5,6). The 7th SAVE -> spill_m=1 for one cycle, no swap_req.
- thr1 at reset issues RESTORE -> fill_m=1, CWP stays 0. WRPR CWP=0 then CANRESTORE=1, then RESTORE -> CWP=7, swap old=0 new=7.
- WRPR CLEANWIN=CANRESTORE=2, CANSAVE=3, then SAVE -> clean_m=1 and no state change.
- SAVE with kill_m=1 -> no trap outputs, counters unchanged, busy low the next cycle.
- Commit with ack withheld 5 cycles -> swap_req held and fields stable; new SAVE with busy=1 dropped. Ack -> req low the next cycle, busy low.
- Same-cycle WRPR CANSAVE=4 on thr2 with thr2 SAVE commit from CANSAVE=6 -> CANSAVE=4, CANRESTORE+1, CWP+1. Reset during SWAP -> req 0 and all reset values restored.

Source files
------------

// File: rtl/sparc_exu_rml_wincnt_pkg.sv
// Shared constants and types for the EXU register-window counter block.
package sparc_exu_rml_wincnt_pkg;

    localparam int NWIN = 8;
    localparam int NTHR = 4;

    localparam logic [2:0] CANSAVE_RST  = 3'd6;
    localparam logic [2:0] CLEANWIN_RST = 3'd7;

    localparam logic [1:0] SEL_CWP        = 2'b00;
    localparam logic [1:0] SEL_CANSAVE    = 2'b01;
    localparam logic [1:0] SEL_CANRESTORE = 2'b10;
    localparam logic [1:0] SEL_CLEANWIN   = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        SWAP = 1'b1
    } swap_state_t;

endpackage

// File: rtl/sparc_exu_rml_inc3.sv
// 3-bit modulo-8 step: +1 when inc is high, -1 otherwise.
module sparc_exu_rml_inc3 (
    input  logic [2:0] din,
    input  logic       inc,
    output logic [2:0] dout
);

    assign dout = inc ? (din + 3'd1) : (din - 3'd1);

endmodule

// File: rtl/sparc_exu_rml_wincnt.sv
// Per-thread CWP/CANSAVE/CANRESTORE/CLEANWIN bookkeeping with SAVE/RESTORE
// trap evaluation in M and a one-outstanding window-swap handshake to the IRF.
//
// state | meaning
// IDLE  | no swap outstanding
// SWAP  | swap_req high, waiting for irf_rml_swap_ack
module sparc_exu_rml_wincnt
    import sparc_exu_rml_wincnt_pkg::*;
(
    input  logic        rclk,
    input  logic        reset,
    input  logic        ecl_rml_save_e,
    input  logic        ecl_rml_restore_e,
    input  logic [1:0]  ecl_rml_tid_e,
    input  logic        ecl_rml_kill_m,
    input  logic        tlu_rml_wr_en,
    input  logic [1:0]  tlu_rml_wr_sel,
    input  logic [1:0]  tlu_rml_wr_tid,
    input  logic [2:0]  tlu_rml_wr_data,
    input  logic        irf_rml_swap_ack,
    output logic        rml_ecl_busy,
    output logic        rml_ecl_spill_m,
    output logic        rml_ecl_fill_m,
    output logic        rml_ecl_clean_m,
    output logic [11:0] rml_cwp_all,
    output logic        rml_irf_swap_req,
    output logic [1:0]  rml_irf_swap_tid,
    output logic [2:0]  rml_irf_old_cwp,
    output logic [2:0]  rml_irf_new_cwp
);

    logic [2:0] cwp        [NTHR];
    logic [2:0] cansave    [NTHR];
    logic [2:0] canrestore [NTHR];
    logic [2:0] cleanwin   [NTHR];

    logic        save_m, restore_m;
    logic [1:0]  tid_m;
    swap_state_t state, state_nxt;

    logic [2:0] cur_cwp, cur_cansave, cur_canrestore, cur_cleanwin, cwp_step;
    logic       m_valid, commit_save, commit_restore, commit, cwp_wr;

    assign m_valid        = save_m | restore_m;
    assign rml_ecl_busy   = m_valid | (state == SWAP);
    assign cur_cwp        = cwp[tid_m];
    assign cur_cansave    = cansave[tid_m];
    assign cur_canrestore = canrestore[tid_m];
    assign cur_cleanwin   = cleanwin[tid_m];

    sparc_exu_rml_inc3 u_inc3 (
        .din  (cur_cwp),
        .inc  (save_m),
        .dout (cwp_step)
    );

    always_comb begin
        rml_ecl_spill_m = save_m & ~ecl_rml_kill_m & (cur_cansave == 3'd0);
        rml_ecl_clean_m = save_m & ~ecl_rml_kill_m & (cur_cansave != 3'd0)
                          & (cur_cleanwin == cur_canrestore);
        rml_ecl_fill_m  = restore_m & ~ecl_rml_kill_m & (cur_canrestore == 3'd0);
        commit_save     = save_m & ~ecl_rml_kill_m & (cur_cansave != 3'd0)
                          & (cur_cleanwin != cur_canrestore);
        commit_restore  = restore_m & ~ecl_rml_kill_m & (cur_canrestore != 3'd0);
        commit          = commit_save | commit_restore;
        // busy low implies no M op, so a CWP write never collides with a commit
        cwp_wr          = tlu_rml_wr_en & (tlu_rml_wr_sel == SEL_CWP) & ~rml_ecl_busy;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (commit | cwp_wr) state_nxt = SWAP;
            SWAP: if (irf_rml_swap_ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign rml_irf_swap_req = (state == SWAP);
    assign rml_cwp_all      = {cwp[3], cwp[2], cwp[1], cwp[0]};

    always_ff @(posedge rclk) begin
        if (reset) begin
            save_m           <= 1'b0;
            restore_m        <= 1'b0;
            tid_m            <= 2'd0;
            state            <= IDLE;
            rml_irf_swap_tid <= 2'd0;
            rml_irf_old_cwp  <= 3'd0;
            rml_irf_new_cwp  <= 3'd0;
            for (int t = 0; t < NTHR; t++) begin
                cwp[t]        <= 3'd0;
                cansave[t]    <= CANSAVE_RST;
                canrestore[t] <= 3'd0;
                cleanwin[t]   <= CLEANWIN_RST;
            end
        end else begin
            save_m    <= ecl_rml_save_e & ~rml_ecl_busy;
            restore_m <= ecl_rml_restore_e & ~rml_ecl_busy;
            if (!rml_ecl_busy) tid_m <= ecl_rml_tid_e;
            state <= state_nxt;

            if (commit) begin
                rml_irf_swap_tid <= tid_m;
                rml_irf_old_cwp  <= cur_cwp;
                rml_irf_new_cwp  <= cwp_step;
            end else if (cwp_wr) begin
                rml_irf_swap_tid <= tlu_rml_wr_tid;
                rml_irf_old_cwp  <= cwp[tlu_rml_wr_tid];
                rml_irf_new_cwp  <= tlu_rml_wr_data;
            end

            for (int t = 0; t < NTHR; t++) begin
                if (commit && tid_m == 2'(t)) begin
                    cwp[t]        <= cwp_step;
                    cansave[t]    <= commit_save ? cur_cansave - 3'd1 : cur_cansave + 3'd1;
                    canrestore[t] <= commit_save ? cur_canrestore + 3'd1 : cur_canrestore - 3'd1;
                end
                if (cwp_wr && tlu_rml_wr_tid == 2'(t))
                    cwp[t] <= tlu_rml_wr_data;
                // TLU counter writes override a same-cycle commit on that field only
                if (tlu_rml_wr_en && tlu_rml_wr_tid == 2'(t)) begin
                    case (tlu_rml_wr_sel)
                        SEL_CANSAVE:    cansave[t]    <= tlu_rml_wr_data;
                        SEL_CANRESTORE: canrestore[t] <= tlu_rml_wr_data;
                        SEL_CLEANWIN:   cleanwin[t]   <= tlu_rml_wr_data;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_sparc_exu_rml_wincnt.sv
// Directed bench: stimulus pushes expected trap/swap events, a monitor pops and compares.
module tb_sparc_exu_rml_wincnt;

    logic        rclk = 1'b0;
    logic        reset = 1'b1;
    logic        save_e = 1'b0, restore_e = 1'b0, kill_m = 1'b0;
    logic [1:0]  tid_e = 2'd0;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_sel = 2'd0, wr_tid = 2'd0;
    logic [2:0]  wr_data = 3'd0;
    logic        ack = 1'b0;
    logic        busy, spill, fill, clean, swap_req;
    logic [11:0] cwp_all;
    logic [1:0]  swap_tid;
    logic [2:0]  old_cwp, new_cwp;

    localparam int K_SWAP = 0, K_SPILL = 1, K_FILL = 2, K_CLEAN = 3;

    typedef struct {
        int         kind;
        logic [1:0] tid;
        logic [2:0] oldc;
        logic [2:0] newc;
    } ev_t;

    ev_t exp_q[$];
    ev_t cur, e;
    int  n_chk = 0, n_fail = 0;
    logic prev_req = 1'b0;

    sparc_exu_rml_wincnt dut (
        .rclk              (rclk),
        .reset             (reset),
        .ecl_rml_save_e    (save_e),
        .ecl_rml_restore_e (restore_e),
        .ecl_rml_tid_e     (tid_e),
        .ecl_rml_kill_m    (kill_m),
        .tlu_rml_wr_en     (wr_en),
        .tlu_rml_wr_sel    (wr_sel),
        .tlu_rml_wr_tid    (wr_tid),
        .tlu_rml_wr_data   (wr_data),
        .irf_rml_swap_ack  (ack),
        .rml_ecl_busy      (busy),
        .rml_ecl_spill_m   (spill),
        .rml_ecl_fill_m    (fill),
        .rml_ecl_clean_m   (clean),
        .rml_cwp_all       (cwp_all),
        .rml_irf_swap_req  (swap_req),
        .rml_irf_swap_tid  (swap_tid),
        .rml_irf_old_cwp   (old_cwp),
        .rml_irf_new_cwp   (new_cwp)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cwp_of(input int t);
        return int'(cwp_all[3*t +: 3]);
    endfunction

    task automatic push(input int kind, input int tid, input int o, input int n);
        ev_t x;
        x.kind = kind;
        x.tid  = 2'(tid);
        x.oldc = 3'(o);
        x.newc = 3'(n);
        exp_q.push_back(x);
    endtask

    // Monitor: pops an expected event whenever the DUT raises a trap or a new swap.
    initial begin
        forever begin
            @(negedge rclk);
            if (spill | fill | clean) begin
                int obs;
                obs = ({clean, fill, spill} == 3'b001) ? K_SPILL :
                      ({clean, fill, spill} == 3'b010) ? K_FILL  :
                      ({clean, fill, spill} == 3'b100) ? K_CLEAN : 7;
                if (exp_q.size() == 0) check("unexpected_trap", obs, -1);
                else begin
                    e = exp_q.pop_front();
                    check("trap_kind", obs, e.kind);
                end
            end
            if (swap_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_swap", 1, 0);
                    cur.tid = swap_tid; cur.oldc = old_cwp; cur.newc = new_cwp;
                end else begin
                    e = exp_q.pop_front();
                    check("swap_kind", K_SWAP, e.kind);
                    check("swap_tid", int'(swap_tid), int'(e.tid));
                    check("swap_old", int'(old_cwp), int'(e.oldc));
                    check("swap_new", int'(new_cwp), int'(e.newc));
                    cur = e;
                end
            end else if (swap_req && prev_req) begin
                check("swap_tid_stable", int'(swap_tid), int'(cur.tid));
                check("swap_old_stable", int'(old_cwp), int'(cur.oldc));
                check("swap_new_stable", int'(new_cwp), int'(cur.newc));
            end
            prev_req = swap_req;
        end
    end

    task automatic issue(input bit is_save, input int tid, input bit kill);
        @(posedge rclk); #1;
        save_e = is_save; restore_e = !is_save; tid_e = 2'(tid);
        @(posedge rclk); #1;
        save_e = 0; restore_e = 0; kill_m = kill;
        @(posedge rclk); #1;
        kill_m = 0;
    endtask

    task automatic wrpr(input logic [1:0] sel, input int tid, input int data);
        @(posedge rclk); #1;
        wr_en = 1; wr_sel = sel; wr_tid = 2'(tid); wr_data = 3'(data);
        @(posedge rclk); #1;
        wr_en = 0;
    endtask

    task automatic wait_ack(input int delay);
        int n = 0;
        while (!swap_req && n < 20) begin
            @(negedge rclk);
            n++;
        end
        check("req_seen", int'(swap_req), 1);
        repeat (delay) @(posedge rclk);
        @(posedge rclk); #1 ack = 1;
        @(posedge rclk); #1 ack = 0;
        @(negedge rclk);
        check("req_after_ack", int'(swap_req), 0);
        check("busy_after_ack", int'(busy), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge rclk);
        #1 reset = 0;
        @(negedge rclk);
        check("rst_cwp_all", int'(cwp_all), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_req", int'(swap_req), 0);
        check("rst_traps", int'({spill, fill, clean}), 0);

        // thr0: six saves, then spill
        for (int i = 0; i < 6; i++) begin
            push(K_SWAP, 0, i, i + 1);
            issue(1, 0, 0);
            wait_ack(0);
            check("t0_cwp", cwp_of(0), i + 1);
        end
        push(K_SPILL, 0, 0, 0);
        issue(1, 0, 0);
        @(negedge rclk);
        check("spill_busy", int'(busy), 0);
        check("spill_req", int'(swap_req), 0);
        check("spill_cwp", cwp_of(0), 6);

        // thr1: fill at reset, WRPR CWP swap, then restore wraps 0->7
        push(K_FILL, 1, 0, 0);
        issue(0, 1, 0);
        @(negedge rclk);
        check("fill_cwp", cwp_of(1), 0);
        check("fill_busy", int'(busy), 0);
        push(K_SWAP, 1, 0, 0);
        wrpr(2'b00, 1, 0);
        wait_ack(0);
        wrpr(2'b10, 1, 1);
        push(K_SWAP, 1, 0, 7);
        issue(0, 1, 0);
        wait_ack(0);
        check("restore_wrap_cwp", cwp_of(1), 7);

        // thr3: clean_window trap
        wrpr(2'b11, 3, 2);
        wrpr(2'b10, 3, 2);
        wrpr(2'b01, 3, 3);
        push(K_CLEAN, 3, 0, 0);
        issue(1, 3, 0);
        @(negedge rclk);
        check("clean_cwp", cwp_of(3), 0);
        check("clean_req", int'(swap_req), 0);

        // killed save on thr1: nothing happens; canrestore still 0 so restore fills
        issue(1, 1, 1);
        @(negedge rclk);
        check("kill_busy", int'(busy), 0);
        check("kill_req", int'(swap_req), 0);
        check("kill_cwp", cwp_of(1), 7);
        push(K_FILL, 1, 0, 0);
        issue(0, 1, 0);
        @(negedge rclk);
        check("kill_fill_cwp", cwp_of(1), 7);

        // thr1 save wraps 7->0 with ack withheld; save and CWP write while busy are dropped
        push(K_SWAP, 1, 7, 0);
        issue(1, 1, 0);
        @(negedge rclk);
        check("held_busy", int'(busy), 1);
        @(posedge rclk); #1;
        save_e = 1; tid_e = 2'd2;
        wr_en = 1; wr_sel = 2'b00; wr_tid = 2'd2; wr_data = 3'd5;
        @(posedge rclk); #1;
        save_e = 0; wr_en = 0;
        repeat (3) @(posedge rclk);
        #1 ack = 1;
        @(posedge rclk); #1 ack = 0;
        @(negedge rclk);
        check("held_req_after_ack", int'(swap_req), 0);
        check("held_busy_after_ack", int'(busy), 0);
        check("held_cwp1", cwp_of(1), 0);
        check("dropped_cwp2", cwp_of(2), 0);

        // thr2: same-cycle WRPR CANSAVE=4 with save commit
        push(K_SWAP, 2, 0, 1);
        @(posedge rclk); #1;
        save_e = 1; tid_e = 2'd2;
        @(posedge rclk); #1;
        save_e = 0;
        wr_en = 1; wr_sel = 2'b01; wr_tid = 2'd2; wr_data = 3'd4;
        @(posedge rclk); #1;
        wr_en = 0;
        wait_ack(0);
        check("same_cycle_cwp", cwp_of(2), 1);
        for (int i = 1; i < 5; i++) begin
            push(K_SWAP, 2, i, i + 1);
            issue(1, 2, 0);
            wait_ack(0);
        end
        push(K_SPILL, 2, 0, 0);
        issue(1, 2, 0);
        @(negedge rclk);
        check("cansave4_cwp", cwp_of(2), 5);
        check("cansave4_req", int'(swap_req), 0);

        // reset asserted mid-swap, ack during and after reset ignored
        push(K_SWAP, 2, 5, 4);
        issue(0, 2, 0);
        @(negedge rclk);
        check("pre_reset_req", int'(swap_req), 1);
        @(posedge rclk); #1;
        reset = 1; ack = 1;
        @(posedge rclk); #1 ack = 0;
        @(negedge rclk);
        check("reset_req_drop", int'(swap_req), 0);
        @(posedge rclk); #1 reset = 0;
        @(posedge rclk); #1 ack = 1;
        @(posedge rclk); #1 ack = 0;
        @(negedge rclk);
        check("post_rst_cwp_all", int'(cwp_all), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_req", int'(swap_req), 0);
        push(K_SWAP, 0, 0, 1);
        issue(1, 0, 0);
        wait_ack(0);
        check("post_rst_save_cwp", cwp_of(0), 1);
        push(K_FILL, 2, 0, 0);
        issue(0, 2, 0);
        @(negedge rclk);
        check("post_rst_fill_cwp", cwp_of(2), 0);

        repeat (3) @(negedge rclk);
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
